// File: rtl/vehicle_request_if.sv
// Vehicle request bus: carries the raw loop sensor and the commanded light code
// into the block, and brings the request, debounced level, queue depth and wait
// time back out to the intersection controller.
interface vehicle_request_if;
    logic        sensor_raw;
    logic [1:0]  light;
    logic        request;
    logic        present;
    logic [7:0]  queue_count;
    logic [15:0] wait_seconds;

    // Controller side: drives the sensor and light, observes the request outputs.
    modport master (
        output sensor_raw,
        output light,
        input  request,
        input  present,
        input  queue_count,
        input  wait_seconds
    );

    // Request block side: consumes the sensor and light, produces the outputs.
    modport slave (
        input  sensor_raw,
        input  light,
        output request,
        output present,
        output queue_count,
        output wait_seconds
    );
endinterface

// File: rtl/vehicle_request.sv
// Vehicle request block for one intersection approach.
// The raw loop sensor is synchronized and debounced into a clean "present"
// level. Rising edges of that level are vehicle arrivals, which a three-state
// FSM (IDLE / WAITING / SERVED) turns into a registered request for the
// intersection controller, a queue depth and a whole-second wait timer.
module vehicle_request #(
    parameter int         DEBOUNCE_TICKS   = 500,
    parameter int         TICKS_PER_SECOND = 10000,
    parameter logic [1:0] GREEN_CODE       = 2'b10
) (
    input  logic            clk,
    input  logic            reset,
    vehicle_request_if.slave bus
);

    // Counter widths: the debounce counter runs 0..DEBOUNCE_TICKS-1 and the
    // prescaler runs 0..TICKS_PER_SECOND-1, so clog2 of the tick count suffices.
    localparam int DB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int PS_W = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SECOND - 1);

    localparam logic [7:0]  QUEUE_MAX   = 8'hFF;
    localparam logic [15:0] SECONDS_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        SERVED  = 2'd2
    } state_t;

    // Synchronizer and debounce state
    logic            sync_meta;
    logic            sync_level;
    logic [DB_W-1:0] db_count;
    logic            present_level;
    logic            present_prev;

    // FSM and datapath state
    state_t          state;
    state_t          state_next;
    logic [7:0]      queue_count;
    logic [7:0]      queue_next;
    logic [15:0]     wait_seconds;
    logic [15:0]     seconds_next;
    logic [PS_W-1:0] prescale;
    logic [PS_W-1:0] prescale_next;
    logic            request_reg;

    // Decoded events
    logic            arrival;
    logic            light_green;
    logic            enter_waiting;
    logic            enter_served;

    // Two-flop synchronizer; the loop pin is asynchronous to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
        end else begin
            sync_meta  <= bus.sensor_raw;
            sync_level <= sync_meta;
        end
    end

    // Debounce: the synchronized level must disagree with the accepted level
    // for DEBOUNCE_TICKS consecutive cycles before it is accepted; any cycle of
    // agreement throws the partial count away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_count      <= '0;
            present_level <= 1'b0;
        end else if (sync_level != present_level) begin
            if (db_count == DB_LAST) begin
                present_level <= sync_level;
                db_count      <= '0;
            end else begin
                db_count <= db_count + 1'b1;
            end
        end else begin
            db_count <= '0;
        end
    end

    // Delayed copy of the debounced level used to find its rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            present_prev <= 1'b0;
        end else begin
            present_prev <= present_level;
        end
    end

    // An arrival is a 0->1 edge of the debounced level; departures are ignored.
    assign arrival     = present_level & ~present_prev;
    assign light_green = (bus.light == GREEN_CODE);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Green always wins: an arrival in the same cycle the
    // light turns green is absorbed by the move to SERVED.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (arrival) begin
                    state_next = light_green ? SERVED : WAITING;
                end
            end
            WAITING: begin
                if (light_green) begin
                    state_next = SERVED;
                end
            end
            SERVED: begin
                if (!light_green) begin
                    state_next = present_level ? WAITING : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign enter_waiting = (state_next == WAITING) && (state != WAITING);
    assign enter_served  = (state_next == SERVED)  && (state != SERVED);

    // Queue depth: cleared on entering SERVED, set to one vehicle on entering
    // WAITING, and counting further arrivals (saturating) while WAITING.
    always_comb begin
        queue_next = queue_count;
        if (enter_served) begin
            queue_next = 8'd0;
        end else if (enter_waiting) begin
            queue_next = 8'd1;
        end else if ((state == WAITING) && arrival && (queue_count != QUEUE_MAX)) begin
            queue_next = queue_count + 8'd1;
        end
    end

    // Wait timer: the prescaler and seconds count restart on every entry to
    // WAITING and only advance while in WAITING; elsewhere the last value holds
    // so the controller can still read how long the approach waited.
    always_comb begin
        seconds_next  = wait_seconds;
        prescale_next = prescale;
        if (enter_waiting) begin
            seconds_next  = 16'd0;
            prescale_next = '0;
        end else if (state == WAITING) begin
            if (prescale == PS_LAST) begin
                prescale_next = '0;
                if (wait_seconds != SECONDS_MAX) begin
                    seconds_next = wait_seconds + 16'd1;
                end
            end else begin
                prescale_next = prescale + 1'b1;
            end
        end
    end

    // Datapath registers; request mirrors the state the edge leaves behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            queue_count  <= 8'd0;
            wait_seconds <= 16'd0;
            prescale     <= '0;
            request_reg  <= 1'b0;
        end else begin
            queue_count  <= queue_next;
            wait_seconds <= seconds_next;
            prescale     <= prescale_next;
            request_reg  <= (state_next == WAITING);
        end
    end

    assign bus.request      = request_reg;
    assign bus.present      = present_level;
    assign bus.queue_count  = queue_count;
    assign bus.wait_seconds = wait_seconds;

endmodule
